axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning the number of 32-bit words of internal storage.
REQ-002 SHALL have parameter ID_WIDTH, default 4, meaning the width of the AXI ID fields.
REQ-003 clock  input  1  sole clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 arid  input  ID_WIDTH  read burst ID.
REQ-006 araddr  input  32  read byte address; bits [1:0] ignored.
REQ-007 arlen  input  8  read beats minus one.
REQ-008 arvalid  input  1  read address valid.
REQ-009 arready  output  1  read address accepted.
REQ-010 rid  output  ID_WIDTH  echo of latched arid.
REQ-011 rdata  output  32  read beat data.
REQ-012 rresp  output  2  per-beat response (00 OKAY, 10 SLVERR).
REQ-013 rlast  output  1  final read beat.
REQ-014 rvalid  output  1  read beat valid.
REQ-015 rready  input  1  master accepts read beat.
REQ-016 awid  input  ID_WIDTH  write burst ID.
REQ-017 awaddr  input  32  write byte address; bits [1:0] ignored.
REQ-018 awlen  input  8  write beats minus one.
REQ-019 awvalid  input  1  write address valid.
REQ-020 awready  output  1  write address accepted.
REQ-021 wdata  input  32  write beat data.
REQ-022 wstrb  input  4  byte enables.
REQ-023 wlast  input  1  master's final-beat marker.
REQ-024 wvalid  input  1  write beat valid.
REQ-025 wready  output  1  write beat accepted.
REQ-026 bid  output  ID_WIDTH  echo of latched awid.
REQ-027 bresp  output  2  burst response (00 OKAY, 10 SLVERR).
REQ-028 bvalid  output  1  write response valid.
REQ-029 bready  input  1  master accepts write response.

Function
REQ-030 SHALL support INCR bursts of 32-bit beats only; word index = addr[31:2], incremented by 1 per beat; no burst-type, size, lock, cache or prot ports exist.
REQ-031 Read FSM SHALL have states R_IDLE (arready=1, rvalid=0) and R_BURST (arready=0, rvalid=1); an AR handshake latches arid, word index and arlen, and moves to R_BURST next cycle with the first beat presented (1-cycle latency).
REQ-032 rdata/rresp SHALL be registered, loaded at AR handshake and at each non-final R handshake from the next word, and held stable while rvalid=1 and rready=0, even if that word is written meanwhile.
REQ-033 rlast SHALL be 1 exactly when the beat counter equals the latched len; an R handshake with rlast=1 returns to R_IDLE, and a new AR is accepted no earlier than the following cycle.
REQ-034 A beat whose word index is >= MEM_WORDS SHALL return rdata=0 and rresp=10; in-range beats return rresp=00.
REQ-035 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1), all other ready/valid outputs 0 in each state; AW handshake latches awid, index and awlen and enters W_DATA.
REQ-036 Each W handshake SHALL write the bytes enabled by wstrb to the current word (skipped if out of range), then increment the index; the beat with counter = len moves to W_RESP regardless of wlast.
REQ-037 bresp SHALL be 10 if any beat was out of range or wlast differed from (counter = len) on any beat, else 00; bvalid is held until bready, then W_IDLE.
REQ-038 Read and write FSMs SHALL operate independently and concurrently; a same-cycle write and read-load of one word yields the old data on rdata.
REQ-039 All valid/ready outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-040 On reset: rvalid=bvalid=wready=0, arready=awready=1, rid=bid=0, rdata=0, rresp=bresp=0, rlast=0, counters 0, both FSMs idle; any burst in progress is abandoned with no response; memory contents are not cleared.

Verification
REQ-041 Write awaddr=0x10, len=0, wdata=0xDEADBEEF, wstrb=0xF, awid=3 -> bid=3, bresp=00; read 0x10, arid=5 -> rdata=0xDEADBEEF, rresp=00, rlast=1, rid=5.
REQ-042 4-beat write at 0x100 data 1,2,3,4; read arlen=3 with rready toggling 1/0 -> beats 1,2,3,4 in order, rlast only on beat 4, rdata stable during stalls.
REQ-043 Write 0xFFFFFFFF to 0x20, then wdata=0x00001234 with wstrb=0x3 -> read returns 0xFFFF1234.
REQ-044 MEM_WORDS=4096, read araddr=0x4000 -> rdata=0, rresp=10; write there -> bresp=10 and no in-range word modified.
REQ-045 awlen=2 with wlast=1 on beat 0 -> three beats still accepted, bresp=10.
REQ-046 Assert reset during R_BURST beat 1 of 4 -> next cycle rvalid=0, arready=1; subsequent read completes normally.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI4 subset bus (INCR bursts of 32-bit beats) connecting a master to axi_sram_slave.
interface axi_sram_slave_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  arid, araddr, arlen, arvalid, rready,
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arid, araddr, arlen, arvalid, rready,
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-only SRAM slave: independent read and write burst FSMs over a word-wide memory
// with byte enables, SLVERR for out-of-range beats and wlast protocol violations.
module axi_sram_slave #(
  parameter int MEM_WORDS = 4096,
  parameter int ID_WIDTH  = 4
) (
  input logic             clock,
  input logic             reset,
  axi_sram_slave_if.slave bus
);
  localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] MEM_WORDS_L = 30'(MEM_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem_r [MEM_WORDS];

  r_state_t            r_state_r, r_state_nx_s;
  logic                r_load_s;
  logic [29:0]         r_load_idx_s;
  logic [31:0]         r_word_s;
  logic [29:0]         r_idx_r;
  logic [7:0]          r_cnt_r, r_len_r;
  logic                arready_r, rvalid_r, rlast_r;
  logic [ID_WIDTH-1:0] rid_r;
  logic [31:0]         rdata_r;
  logic [1:0]          rresp_r;

  w_state_t            w_state_r, w_state_nx_s;
  logic                w_hs_s, w_we_s, w_last_beat_s, w_beat_err_s;
  logic [29:0]         w_idx_r;
  logic [7:0]          w_cnt_r, w_len_r;
  logic                w_err_r;
  logic                awready_r, wready_r, bvalid_r;
  logic [ID_WIDTH-1:0] bid_r;
  logic [1:0]          bresp_r;

  logic                unused_s;
  assign unused_s = &{1'b0, bus.araddr[1:0], bus.awaddr[1:0]};

  function automatic logic in_range(input logic [29:0] idx);
    return (idx < MEM_WORDS_L);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return m;
  endfunction

  // Read FSM next state and load strobe for the word to present next.
  always_comb begin
    r_state_nx_s = r_state_r;
    r_load_s     = 1'b0;
    r_load_idx_s = r_idx_r + 30'd1;
    case (r_state_r)
      R_IDLE: begin
        if (bus.arvalid) begin
          r_state_nx_s = R_BURST;
          r_load_s     = 1'b1;
          r_load_idx_s = bus.araddr[31:2];
        end else begin
          r_state_nx_s = R_IDLE;
        end
      end
      R_BURST: begin
        if (bus.rready && rlast_r) begin
          r_state_nx_s = R_IDLE;
        end else if (bus.rready) begin
          r_load_s = 1'b1;
        end else begin
          r_state_nx_s = R_BURST;
        end
      end
      default: r_state_nx_s = R_IDLE;
    endcase
  end

  // Memory lookup for the beat about to be loaded; out-of-range reads as zero.
  always_comb begin
    if (in_range(r_load_idx_s)) begin
      r_word_s = mem_r[r_load_idx_s[AW-1:0]];
    end else begin
      r_word_s = 32'd0;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state_r <= R_IDLE;
    else       r_state_r <= r_state_nx_s;
  end

  // Read channel datapath and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= '0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
      r_idx_r   <= 30'd0;
      r_cnt_r   <= 8'd0;
      r_len_r   <= 8'd0;
    end else begin
      arready_r <= (r_state_nx_s == R_IDLE);
      rvalid_r  <= (r_state_nx_s == R_BURST);
      if (r_load_s) begin
        r_idx_r <= r_load_idx_s;
        rdata_r <= r_word_s;
        rresp_r <= in_range(r_load_idx_s) ? RESP_OKAY : RESP_SLVERR;
        if (r_state_r == R_IDLE) begin
          rid_r   <= bus.arid;
          r_len_r <= bus.arlen;
          r_cnt_r <= 8'd0;
          rlast_r <= (bus.arlen == 8'd0);
        end else begin
          r_cnt_r <= r_cnt_r + 8'd1;
          rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
        end
      end else if (r_state_nx_s == R_IDLE) begin
        rlast_r <= 1'b0;
      end
    end
  end

  // Write FSM next state, memory write enable and per-beat error detection.
  always_comb begin
    w_state_nx_s  = w_state_r;
    w_hs_s        = 1'b0;
    w_we_s        = 1'b0;
    w_last_beat_s = (w_cnt_r == w_len_r);
    w_beat_err_s  = !in_range(w_idx_r) || (bus.wlast != w_last_beat_s);
    case (w_state_r)
      W_IDLE: begin
        if (bus.awvalid) w_state_nx_s = W_DATA;
        else             w_state_nx_s = W_IDLE;
      end
      W_DATA: begin
        if (bus.wvalid) begin
          w_hs_s       = 1'b1;
          w_we_s       = in_range(w_idx_r) && !reset;
          w_state_nx_s = w_last_beat_s ? W_RESP : W_DATA;
        end else begin
          w_state_nx_s = W_DATA;
        end
      end
      W_RESP: begin
        if (bus.bready) w_state_nx_s = W_IDLE;
        else            w_state_nx_s = W_RESP;
      end
      default: w_state_nx_s = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clock) begin
    if (reset) w_state_r <= W_IDLE;
    else       w_state_r <= w_state_nx_s;
  end

  // Write channel datapath and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= RESP_OKAY;
      w_idx_r   <= 30'd0;
      w_cnt_r   <= 8'd0;
      w_len_r   <= 8'd0;
      w_err_r   <= 1'b0;
    end else begin
      awready_r <= (w_state_nx_s == W_IDLE);
      wready_r  <= (w_state_nx_s == W_DATA);
      bvalid_r  <= (w_state_nx_s == W_RESP);
      if ((w_state_r == W_IDLE) && bus.awvalid) begin
        bid_r   <= bus.awid;
        w_idx_r <= bus.awaddr[31:2];
        w_len_r <= bus.awlen;
        w_cnt_r <= 8'd0;
        w_err_r <= 1'b0;
      end else if (w_hs_s) begin
        w_idx_r <= w_idx_r + 30'd1;
        w_cnt_r <= w_cnt_r + 8'd1;
        w_err_r <= w_err_r | w_beat_err_s;
        if (w_last_beat_s) begin
          bresp_r <= (w_err_r | w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (w_we_s) begin
      mem_r[w_idx_r[AW-1:0]] <= merge_bytes(mem_r[w_idx_r[AW-1:0]], bus.wdata, bus.wstrb);
    end
  end

  assign bus.arready = arready_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rlast   = rlast_r;
  assign bus.rid     = rid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bid     = bid_r;
  assign bus.bresp   = bresp_r;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: expected read beats and write responses are queued
// when a request is issued and compared when the slave presents them.
module tb_axi_sram_slave;
  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];

  axi_sram_slave_if #(.ID_WIDTH(4)) bus ();

  axi_sram_slave #(.MEM_WORDS(4096), .ID_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
    rexp_t e;
    e.data = d; e.resp = resp; e.last = last; e.id = id;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    bexp_t e;
    e.id = id; e.resp = resp;
    bq.push_back(e);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk("ar_timeout", 32'(n < 50), 32'd1);
    @(negedge clock);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_collect(input int nbeats, input bit stall);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      rexp_t e;
      while (bus.rvalid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
      chk("r_timeout", 32'(n < 50), 32'd1);
      e = rq.pop_front();
      if (stall) begin
        bus.rready = 1'b0;
        chk("rdata_pre_stall", bus.rdata, e.data);
        @(negedge clock);
        chk("rvalid_stall", 32'(bus.rvalid), 32'd1);
      end
      bus.rready = 1'b1;
      chk("rdata", bus.rdata, e.data);
      chk("rresp", 32'(bus.rresp), 32'(e.resp));
      chk("rlast", 32'(bus.rlast), 32'(e.last));
      chk("rid", 32'(bus.rid), 32'(e.id));
      @(negedge clock);
      bus.rready = 1'b0;
    end
  endtask

  task automatic w_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] d0, input logic [3:0] strb, input int last_at);
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk("aw_timeout", 32'(n < 50), 32'd1);
    @(negedge clock);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      int m = 0;
      bus.wdata = d0 + 32'(i); bus.wstrb = strb; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
      while (bus.wready !== 1'b1 && m < 50) begin @(negedge clock); m++; end
      chk("w_timeout", 32'(m < 50), 32'd1);
      @(negedge clock);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_collect();
    int n = 0;
    bexp_t e;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk("b_timeout", 32'(n < 50), 32'd1);
    e = bq.pop_front();
    chk("bid", 32'(bus.bid), 32'(e.id));
    chk("bresp", 32'(bus.bresp), 32'(e.resp));
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
    chk("bvalid_drop", 32'(bus.bvalid), 32'd0);
    chk("awready_back", 32'(bus.awready), 32'd1);
  endtask

  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rid_bid", 32'({bus.rid, bus.bid}), 32'd0);
    chk("rst_rdata",   bus.rdata, 32'd0);
    chk("rst_resp",    32'({bus.rresp, bus.bresp, bus.rlast}), 32'd0);

    // single-beat write then read back
    push_b(4'd3, 2'b00);
    w_burst(4'd3, 32'h10, 8'd0, 32'hDEADBEEF, 4'hF, 0);
    b_collect();
    push_r(32'hDEADBEEF, 2'b00, 1'b1, 4'd5);
    ar_send(4'd5, 32'h10, 8'd0);
    r_collect(1, 1'b0);

    // four-beat burst, read back with rready stalls
    push_b(4'd1, 2'b00);
    w_burst(4'd1, 32'h100, 8'd3, 32'd1, 4'hF, 3);
    b_collect();
    for (int i = 0; i < 4; i++) push_r(32'(i + 1), 2'b00, (i == 3), 4'd2);
    ar_send(4'd2, 32'h100, 8'd3);
    r_collect(4, 1'b1);

    // partial byte strobes merge into existing word
    push_b(4'd0, 2'b00);
    w_burst(4'd0, 32'h20, 8'd0, 32'hFFFFFFFF, 4'hF, 0);
    b_collect();
    push_b(4'd0, 2'b00);
    w_burst(4'd0, 32'h20, 8'd0, 32'h00001234, 4'h3, 0);
    b_collect();
    push_r(32'hFFFF1234, 2'b00, 1'b1, 4'd4);
    ar_send(4'd4, 32'h20, 8'd0);
    r_collect(1, 1'b0);

    // presented read beat holds its data while the same word is overwritten
    push_r(32'hDEADBEEF, 2'b00, 1'b1, 4'd6);
    ar_send(4'd6, 32'h10, 8'd0);
    push_b(4'd4, 2'b00);
    w_burst(4'd4, 32'h10, 8'd0, 32'h0BADF00D, 4'hF, 0);
    b_collect();
    r_collect(1, 1'b0);
    push_r(32'h0BADF00D, 2'b00, 1'b1, 4'd6);
    ar_send(4'd6, 32'h10, 8'd0);
    r_collect(1, 1'b0);

    // out-of-range access: SLVERR and no aliasing onto word 0
    push_b(4'd0, 2'b00);
    w_burst(4'd0, 32'h0, 8'd0, 32'h13579BDF, 4'hF, 0);
    b_collect();
    push_r(32'd0, 2'b10, 1'b1, 4'd7);
    ar_send(4'd7, 32'h4000, 8'd0);
    r_collect(1, 1'b0);
    push_b(4'd7, 2'b10);
    w_burst(4'd7, 32'h4000, 8'd0, 32'hA5A5A5A5, 4'hF, 0);
    b_collect();
    push_r(32'h13579BDF, 2'b00, 1'b1, 4'd1);
    ar_send(4'd1, 32'h0, 8'd0);
    r_collect(1, 1'b0);

    // burst straddling the top of memory
    push_b(4'd2, 2'b10);
    w_burst(4'd2, 32'h3FFC, 8'd1, 32'h77, 4'hF, 1);
    b_collect();
    push_r(32'h77, 2'b00, 1'b0, 4'd3);
    push_r(32'd0, 2'b10, 1'b1, 4'd3);
    ar_send(4'd3, 32'h3FFC, 8'd1);
    r_collect(2, 1'b0);

    // early wlast: all three beats still taken, SLVERR
    push_b(4'd9, 2'b10);
    w_burst(4'd9, 32'h200, 8'd2, 32'h50, 4'hF, 0);
    b_collect();
    for (int i = 0; i < 3; i++) push_r(32'h50 + 32'(i), 2'b00, (i == 2), 4'd9);
    ar_send(4'd9, 32'h200, 8'd2);
    r_collect(3, 1'b0);

    // reset in the middle of a read burst
    push_r(32'd1, 2'b00, 1'b0, 4'd8);
    ar_send(4'd8, 32'h100, 8'd3);
    r_collect(1, 1'b0);
    chk("mid_burst_beat1", bus.rdata, 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_mid_arready", 32'(bus.arready), 32'd1);
    for (int i = 0; i < 4; i++) push_r(32'(i + 1), 2'b00, (i == 3), 4'd10);
    ar_send(4'd10, 32'h100, 8'd3);
    r_collect(4, 1'b0);
    chk("final_rvalid", 32'(bus.rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
